// File: rtl/pc_target_lut.sv
// rtl/pc_target_lut.sv - programmable branch/jump target lookup table with registered read
// 256 x D flop table indexed by an 8-bit tag; one-cycle read latency, write-first on tag collision.
module pc_target_lut #(
  parameter int D  = 12,
  parameter int TW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          rd_en,
  input  logic [TW-1:0] tag,
  output logic [D-1:0]  target,
  output logic          target_valid,
  input  logic          wr_en,
  input  logic [TW-1:0] wr_tag,
  input  logic [D-1:0]  wr_data
);

  localparam int DEPTH = 2 ** TW;

  logic [D-1:0] r_mem [DEPTH];
  logic [D-1:0] r_target;
  logic         r_target_valid;

  logic         w_bypass;
  logic [D-1:0] w_rd_data;

  // wr_en gates the compare so an idle write port never perturbs reads
  assign w_bypass  = wr_en && (wr_tag == tag);
  assign w_rd_data = w_bypass ? wr_data : r_mem[tag];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= D'(i);
      end
      r_target       <= '0;
      r_target_valid <= 1'b0;
    end else begin
      if (wr_en) begin
        r_mem[wr_tag] <= wr_data;
      end
      r_target_valid <= rd_en;
      if (rd_en) begin
        r_target <= w_rd_data;
      end
    end
  end

  assign target       = r_target;
  assign target_valid = r_target_valid;

endmodule

// File: tb/tb_pc_target_lut.sv
// tb/tb_pc_target_lut.sv - scoreboard bench for pc_target_lut
// Driver pushes hand-computed targets on each accepted read; a monitor pops on target_valid.
module tb_pc_target_lut;

  localparam int D  = 12;
  localparam int TW = 8;

  logic          clk;
  logic          rst_n;
  logic          rd_en;
  logic [TW-1:0] tag;
  logic [D-1:0]  target;
  logic          target_valid;
  logic          wr_en;
  logic [TW-1:0] wr_tag;
  logic [D-1:0]  wr_data;

  int errors;
  int checks;
  logic [D-1:0] exp_q[$];

  pc_target_lut #(.D(D), .TW(TW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rd_en        (rd_en),
    .tag          (tag),
    .target       (target),
    .target_valid (target_valid),
    .wr_en        (wr_en),
    .wr_tag       (wr_tag),
    .wr_data      (wr_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic rst, input logic rd, input logic [TW-1:0] t,
                       input logic wr, input logic [TW-1:0] wt, input logic [D-1:0] wd,
                       input logic [D-1:0] exp_t);
    @(negedge clk);
    rst_n   = rst;
    rd_en   = rd;
    tag     = t;
    wr_en   = wr;
    wr_tag  = wt;
    wr_data = wd;
    if (rst && rd) exp_q.push_back(exp_t);
  endtask

  task automatic chk_idle(input string name, input logic [D-1:0] exp_t);
    @(posedge clk);
    #2;
    checks++;
    if (target_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s valid: got %b want 0", name, target_valid);
    end
    checks++;
    if (target !== exp_t) begin
      errors++;
      $display("FAIL %s target: got %h want %h", name, target, exp_t);
    end
  endtask

  // Monitor: every valid output must match the oldest outstanding expectation
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (target_valid === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_valid: got target %h with no read outstanding", target);
        end else begin
          automatic logic [D-1:0] e = exp_q.pop_front();
          if (target !== e) begin
            errors++;
            $display("FAIL read_data: got %h want %h", target, e);
          end
        end
      end
    end
  end

  initial begin
    errors  = 0;
    checks  = 0;
    rst_n   = 1'b0;
    rd_en   = 1'b0;
    tag     = '0;
    wr_en   = 1'b0;
    wr_tag  = '0;
    wr_data = '0;

    drive(1'b0, 1'b0, 8'd0, 1'b0, 8'd0, 12'h000, 12'h000);
    drive(1'b0, 1'b0, 8'd0, 1'b0, 8'd0, 12'h000, 12'h000);
    chk_idle("reset_state", 12'h000);

    drive(1'b1, 1'b1, 8'd0,   1'b0, 8'd0, 12'h000, 12'd0);
    drive(1'b1, 1'b1, 8'd37,  1'b0, 8'd0, 12'h000, 12'd37);
    drive(1'b1, 1'b1, 8'd255, 1'b0, 8'd0, 12'h000, 12'd255);
    drive(1'b1, 1'b0, 8'd0,   1'b0, 8'd0, 12'h000, 12'h000);
    chk_idle("after_reset_reads", 12'd255);

    drive(1'b1, 1'b0, 8'd0, 1'b1, 8'd5, 12'hABC, 12'h000);
    drive(1'b1, 1'b1, 8'd5, 1'b0, 8'd0, 12'h000, 12'hABC);
    drive(1'b1, 1'b1, 8'd6, 1'b0, 8'd0, 12'h000, 12'd6);

    drive(1'b1, 1'b1, 8'd9,  1'b1, 8'd9,  12'h123, 12'h123);
    drive(1'b1, 1'b1, 8'd11, 1'b1, 8'd10, 12'h777, 12'd11);
    drive(1'b1, 1'b1, 8'd9,  1'b0, 8'd0,  12'h000, 12'h123);
    drive(1'b1, 1'b1, 8'd10, 1'b0, 8'd0,  12'h000, 12'h777);

    drive(1'b1, 1'b1, 8'd200, 1'b0, 8'd0, 12'h000, 12'd200);
    drive(1'b1, 1'b0, 8'hAA,  1'b0, 8'd0, 12'h000, 12'h000);
    chk_idle("hold_1", 12'd200);
    drive(1'b1, 1'b0, 8'h55,  1'b0, 8'd0, 12'h000, 12'h000);
    chk_idle("hold_2", 12'd200);
    drive(1'b1, 1'b0, 8'hAA,  1'b0, 8'd0, 12'h000, 12'h000);
    chk_idle("hold_3", 12'd200);

    drive(1'b1, 1'b0, 8'd0, 1'b1, 8'd5, 12'hFFF, 12'h000);
    drive(1'b0, 1'b1, 8'd5, 1'b1, 8'd7, 12'h999, 12'h000);
    chk_idle("reset_mid_op", 12'h000);
    drive(1'b1, 1'b1, 8'd5, 1'b0, 8'd0, 12'h000, 12'd5);
    drive(1'b1, 1'b1, 8'd7, 1'b0, 8'd0, 12'h000, 12'd7);
    drive(1'b1, 1'b1, 8'd9, 1'b0, 8'd0, 12'h000, 12'd9);

    for (int i = 0; i < 256; i++) begin
      drive(1'b1, 1'b1, 8'(i), 1'b0, 8'd0, 12'h000, 12'(i));
    end
    drive(1'b1, 1'b0, 8'd0, 1'b0, 8'd0, 12'h000, 12'h000);
    chk_idle("after_sweep", 12'd255);

    repeat (2) @(posedge clk);
    #3;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL outstanding_reads: got %0d unreturned want 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
